// File: rtl/inst_fetcher_pkg.sv
// Shared constants and types for the instruction fetcher: widths, RV32I control-flow opcodes and
// fetch FSM state encodings.
package inst_fetcher_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned BHT_IDX_W  = 6;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StWaitJr,
    StDiscard
  } fetch_state_e;

endpackage

// File: rtl/inst_fetcher_branch_predictor.sv
// Branch history table of 2-bit saturating counters: combinational read, synchronous update.
// A read of the entry being updated in the same cycle sees the old counter.
module inst_fetcher_branch_predictor #(
  parameter int unsigned ADDR_WIDTH = inst_fetcher_pkg::ADDR_WIDTH,
  parameter int unsigned BHT_IDX_W  = inst_fetcher_pkg::BHT_IDX_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rdy_i,
  input  logic [ADDR_WIDTH-1:0] rd_pc_i,
  output logic                  rd_taken_o,
  input  logic                  upd_en_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i
);

  localparam int unsigned NumEntries = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [NumEntries];
  logic [1:0]           bht_d [NumEntries];
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [1:0]           upd_cnt;

  assign rd_idx     = rd_pc_i[BHT_IDX_W+1:2];
  assign upd_idx    = upd_pc_i[BHT_IDX_W+1:2];
  assign upd_cnt    = bht_q[upd_idx];
  assign rd_taken_o = bht_q[rd_idx][1];

  // Word-aligned PCs: low bits and high tag bits do not select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc_i[1:0], rd_pc_i[ADDR_WIDTH-1:BHT_IDX_W+2],
                            upd_pc_i[1:0], upd_pc_i[ADDR_WIDTH-1:BHT_IDX_W+2]};

  always_comb begin
    bht_d = bht_q;
    if (rdy_i && upd_en_i) begin
      if (upd_taken_i) begin
        bht_d[upd_idx] = (upd_cnt == 2'b11) ? upd_cnt : upd_cnt + 2'b01;
      end else begin
        bht_d[upd_idx] = (upd_cnt == 2'b00) ? upd_cnt : upd_cnt - 2'b01;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumEntries; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      bht_q <= bht_d;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: owns the PC, issues one fetch request at a time, redirects on JAL and
// predicted-taken branches, parks after JALR, and drops in-flight fetches on ROB flush.
module inst_fetcher #(
  parameter int unsigned ADDR_WIDTH = inst_fetcher_pkg::ADDR_WIDTH,
  parameter int unsigned INST_WIDTH = inst_fetcher_pkg::INST_WIDTH,
  parameter int unsigned BHT_IDX_W  = inst_fetcher_pkg::BHT_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  if2ctrl_en,
  output logic [ADDR_WIDTH-1:0] next_PC,
  input  logic                  inst_rdy,
  input  logic [INST_WIDTH-1:0] inst_out,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_PC,
  input  logic                  bp_upd_en,
  input  logic [ADDR_WIDTH-1:0] bp_upd_PC,
  input  logic                  bp_taken,
  output logic                  fetch_valid,
  output logic [INST_WIDTH-1:0] fetch_inst,
  output logic [ADDR_WIDTH-1:0] fetch_PC,
  output logic                  fetch_pred
);

  import inst_fetcher_pkg::*;

  function automatic logic [ADDR_WIDTH-1:0] imm_b(input logic [INST_WIDTH-1:0] inst);
    logic [12:0] raw;
    raw = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    return {{(ADDR_WIDTH-13){raw[12]}}, raw};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] imm_j(input logic [INST_WIDTH-1:0] inst);
    logic [20:0] raw;
    raw = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return {{(ADDR_WIDTH-21){raw[20]}}, raw};
  endfunction

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;
  logic                  fv_q, fv_d;
  logic [INST_WIDTH-1:0] finst_q, finst_d;
  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  logic                  fpred_q, fpred_d;

  logic [6:0]            opcode;
  logic                  bht_taken;
  logic                  pred;

  assign opcode = inst_out[6:0];
  assign pred   = (opcode == OP_BRANCH) && bht_taken;

  inst_fetcher_branch_predictor #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BHT_IDX_W  (BHT_IDX_W)
  ) u_bp (
    .clk_i       (clk),
    .rst_i       (rst_in),
    .rdy_i       (rdy_in),
    .rd_pc_i     (pc_q),
    .rd_taken_o  (bht_taken),
    .upd_en_i    (bp_upd_en),
    .upd_pc_i    (bp_upd_PC),
    .upd_taken_i (bp_taken)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    next_pc_d = next_pc_q;
    fv_d      = 1'b0;
    finst_d   = finst_q;
    fpc_d     = fpc_q;
    fpred_d   = fpred_q;

    if (flush) begin
      pc_d    = flush_PC;
      finst_d = '0;
      fpc_d   = '0;
      fpred_d = 1'b0;
      if (state_q == StDiscard) begin
        if (inst_rdy) begin
          state_d = StFetch;
          req_d   = 1'b0;
        end
      end else if (req_q && !inst_rdy) begin
        // Request to the controller cannot be withdrawn; hold it and drop its answer.
        state_d = StDiscard;
      end else begin
        state_d = StFetch;
        req_d   = 1'b0;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (req_q) begin
            if (inst_rdy) begin
              req_d   = 1'b0;
              finst_d = inst_out;
              fpc_d   = pc_q;
              fpred_d = pred;
              fv_d    = !stall;
              if (pred) begin
                pc_d = pc_q + imm_b(inst_out);
              end else if (opcode == OP_JAL) begin
                pc_d = pc_q + imm_j(inst_out);
              end else begin
                pc_d = pc_q + ADDR_WIDTH'(4);
              end
              if (stall) begin
                state_d = StHold;
              end else if (opcode == OP_JALR) begin
                state_d = StWaitJr;
              end
            end
          end else if (!stall) begin
            req_d     = 1'b1;
            next_pc_d = pc_q;
          end
        end
        StHold: begin
          if (!stall) begin
            fv_d    = 1'b1;
            state_d = (finst_q[6:0] == OP_JALR) ? StWaitJr : StFetch;
          end
        end
        StWaitJr: begin
          state_d = StWaitJr;
        end
        StDiscard: begin
          if (inst_rdy) begin
            req_d   = 1'b0;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      req_q     <= 1'b0;
      next_pc_q <= '0;
      fv_q      <= 1'b0;
      finst_q   <= '0;
      fpc_q     <= '0;
      fpred_q   <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      next_pc_q <= next_pc_d;
      fv_q      <= fv_d;
      finst_q   <= finst_d;
      fpc_q     <= fpc_d;
      fpred_q   <= fpred_d;
    end
  end

  assign if2ctrl_en  = req_q;
  assign next_PC     = next_pc_q;
  assign fetch_valid = fv_q;
  assign fetch_inst  = finst_q;
  assign fetch_PC    = fpc_q;
  assign fetch_pred  = fpred_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: sequential fetch, JAL, BHT-predicted branch, JALR park,
// flush during a pending request, stall hold, rdy_in hold and asynchronous reset.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, inst_rdy, stall, flush, bp_upd_en, bp_taken;
  logic [31:0] inst_out, flush_PC, bp_upd_PC;
  logic        if2ctrl_en, fetch_valid, fetch_pred;
  logic [31:0] next_PC, fetch_inst, fetch_PC;

  int ncmp = 0;
  int nerr = 0;
  logic seen;

  localparam logic [31:0] ADDI1   = 32'h0010_0093;
  localparam logic [31:0] ADDI2   = 32'h0020_0113;
  localparam logic [31:0] ADDI3   = 32'h0030_0193;
  localparam logic [31:0] JAL_P16 = 32'h0100_006F;
  localparam logic [31:0] JAL_P32 = 32'h0200_006F;
  localparam logic [31:0] JAL_M4  = 32'hFFDF_F06F;
  localparam logic [31:0] JAL_P72 = 32'h0480_006F;
  localparam logic [31:0] JAL_NEG = 32'hE21F_F06F; // -480
  localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
  localparam logic [31:0] JALR0   = 32'h0000_8067;

  inst_fetcher dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .if2ctrl_en  (if2ctrl_en),
    .next_PC     (next_PC),
    .inst_rdy    (inst_rdy),
    .inst_out    (inst_out),
    .stall       (stall),
    .flush       (flush),
    .flush_PC    (flush_PC),
    .bp_upd_en   (bp_upd_en),
    .bp_upd_PC   (bp_upd_PC),
    .bp_taken    (bp_taken),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_PC    (fetch_PC),
    .fetch_pred  (fetch_pred)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (if2ctrl_en) break;
      tick();
    end
    chk("req_seen", {31'd0, if2ctrl_en}, 32'd1);
  endtask

  // Answer the next request with one word; returns just after the handshake edge.
  task automatic serve(input logic [31:0] addr, input logic [31:0] word);
    wait_req();
    chk("req_addr", next_PC, addr);
    inst_out = word;
    inst_rdy = 1'b1;
    tick();
    inst_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; inst_rdy = 1'b0; inst_out = '0; stall = 1'b0;
    flush = 1'b0; flush_PC = '0; bp_upd_en = 1'b0; bp_upd_PC = '0; bp_taken = 1'b0;
    tick();
    tick();
    chk("rst_en",    {31'd0, if2ctrl_en},  32'd0);
    chk("rst_npc",   next_PC,              32'd0);
    chk("rst_fv",    {31'd0, fetch_valid}, 32'd0);
    chk("rst_finst", fetch_inst,           32'd0);
    chk("rst_fpc",   fetch_PC,             32'd0);
    chk("rst_fpred", {31'd0, fetch_pred},  32'd0);
    rst_in = 1'b0;

    // Sequential fetch
    serve(32'h0, ADDI1);
    chk("seq_fv",    {31'd0, fetch_valid}, 32'd1);
    chk("seq_fpc0",  fetch_PC,             32'h0);
    chk("seq_finst", fetch_inst,           ADDI1);
    chk("seq_idle",  {31'd0, if2ctrl_en},  32'd0);
    serve(32'h4, ADDI2);
    chk("seq_fpc4",  fetch_PC, 32'h4);
    serve(32'h8, ADDI1);
    chk("seq_fpc8",  fetch_PC, 32'h8);
    serve(32'hC, ADDI1);
    chk("seq_fpcC",  fetch_PC, 32'hC);

    // JAL +16 at 0x10
    serve(32'h10, JAL_P16);
    chk("jal_fpc",   fetch_PC,            32'h10);
    chk("jal_fpred", {31'd0, fetch_pred}, 32'd0);
    serve(32'h20, JAL_P32);

    // BEQ -8 at 0x40: weakly not taken, then trained taken
    serve(32'h40, BEQ_M8);
    chk("beq_nt_pred", {31'd0, fetch_pred}, 32'd0);
    chk("beq_nt_fpc",  fetch_PC,            32'h40);
    bp_upd_en = 1'b1; bp_upd_PC = 32'h40; bp_taken = 1'b1;
    tick();
    tick();
    bp_upd_en = 1'b0;
    serve(32'h44, JAL_M4);
    serve(32'h40, BEQ_M8);
    chk("beq_t_pred",  {31'd0, fetch_pred}, 32'd1);
    serve(32'h38, JAL_P72);

    // JALR at 0x80 parks until flush
    serve(32'h80, JALR0);
    chk("jalr_fv",  {31'd0, fetch_valid}, 32'd1);
    chk("jalr_fpc", fetch_PC,             32'h80);
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= if2ctrl_en;
    end
    chk("jalr_parked", {31'd0, seen}, 32'd0);
    flush = 1'b1; flush_PC = 32'h200;
    tick();
    flush = 1'b0;
    chk("jr_flush_idle", {31'd0, if2ctrl_en}, 32'd0);
    chk("jr_flush_fv",   {31'd0, fetch_valid}, 32'd0);
    tick();
    chk("jr_flush_req",  {31'd0, if2ctrl_en}, 32'd1);
    serve(32'h200, ADDI1);

    // Flush while the request at 0x24 is outstanding
    serve(32'h204, JAL_NEG);
    wait_req();
    chk("disc_pre_addr", next_PC, 32'h24);
    flush = 1'b1; flush_PC = 32'h300;
    tick();
    flush = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      chk("disc_en",   {31'd0, if2ctrl_en}, 32'd1);
      chk("disc_addr", next_PC,             32'h24);
      seen |= fetch_valid;
      tick();
    end
    inst_out = ADDI3;
    inst_rdy = 1'b1;
    tick();
    inst_rdy = 1'b0;
    seen |= fetch_valid;
    chk("disc_dropped", {31'd0, seen}, 32'd0);
    serve(32'h300, ADDI1);
    chk("disc_fpc", fetch_PC, 32'h300);

    // Stall at the handshake for 5 cycles
    wait_req();
    chk("stall_addr", next_PC, 32'h304);
    stall = 1'b1;
    inst_out = ADDI2;
    inst_rdy = 1'b1;
    tick();
    inst_rdy = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      seen |= fetch_valid | if2ctrl_en;
      tick();
    end
    chk("stall_quiet", {31'd0, seen}, 32'd0);
    stall = 1'b0;
    tick();
    chk("stall_fv",    {31'd0, fetch_valid}, 32'd1);
    chk("stall_finst", fetch_inst,           ADDI2);
    chk("stall_fpc",   fetch_PC,             32'h304);

    // rdy_in low freezes everything, even with inst_rdy high
    wait_req();
    chk("rdy_addr", next_PC, 32'h308);
    rdy_in = 1'b0;
    inst_out = ADDI3;
    inst_rdy = 1'b1;
    tick();
    tick();
    chk("rdy_hold_en", {31'd0, if2ctrl_en},  32'd1);
    chk("rdy_hold_fv", {31'd0, fetch_valid}, 32'd0);
    rdy_in = 1'b1;
    tick();
    inst_rdy = 1'b0;
    chk("rdy_fv",  {31'd0, fetch_valid}, 32'd1);
    chk("rdy_fpc", fetch_PC,             32'h308);

    // Asynchronous reset mid-request
    wait_req();
    chk("arst_pre", next_PC, 32'h30C);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_en",  {31'd0, if2ctrl_en},  32'd0);
    chk("arst_npc", next_PC,              32'd0);
    chk("arst_fpc", fetch_PC,             32'd0);
    chk("arst_fv",  {31'd0, fetch_valid}, 32'd0);
    tick();
    rst_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
